// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Elastic inter-stage pipeline register. It uses a two-entry
//            main+skid buffer with a valid/ready handshake on both sides, a
//            registered in_ready, a synchronous flush, and destination-register
//            taps for hazard and forwarding logic.
// Options  : PIPE_SKID_STALL_CNT_EN enables a saturating output stall counter.
//            Without it, stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic [RD_W-1:0]   skid_rd,
    output logic              skid_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State bits double as the entry valids: bit1 = skid valid, bit0 = main valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic [RD_W-1:0]     r_main_rd;
    logic                r_main_we;
    logic [DATA_W-1:0]   r_skid_data;
    logic [RD_W-1:0]     r_skid_rd;
    logic                r_skid_we;

    logic                w_main_vld;
    logic                w_skid_vld;
    logic                w_in_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid_in;

    assign w_main_vld = r_state[0];
    assign w_skid_vld = r_state[1];
    assign w_in_fire  = in_valid & r_in_ready;

    // Next state and buffer load selects.
    // Flush overrides every transition and suppresses all loads, so the
    // payload fields keep their last values.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && out_ready) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid_in = 1'b1;
                    w_state_nxt    = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (out_ready) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
        end
    end

    // State register. in_ready is registered from the next skid-valid bit,
    // which keeps the ready path free of combinational logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= ~w_state_nxt[1];
        end
    end

    // Main entry payload. It is fed from the input, or from the skid entry
    // when the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_we   <= 1'b0;
        end else if (w_load_main_in) begin
            r_main_data <= in_data;
            r_main_rd   <= in_rd;
            r_main_we   <= in_we;
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_rd   <= r_skid_rd;
            r_main_we   <= r_skid_we;
        end
    end

    // Skid entry payload. It captures the input only when main is occupied
    // and blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_we   <= 1'b0;
        end else if (w_load_skid_in) begin
            r_skid_data <= in_data;
            r_skid_rd   <= in_rd;
            r_skid_we   <= in_we;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count the cycles in which the head is offered but not taken,
    // saturating at all-ones. Flush has no effect on this counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_vld;
    assign out_data  = r_main_data;
    assign out_rd    = r_main_rd;
    assign out_we    = r_main_we & w_main_vld;
    assign skid_rd   = r_skid_rd;
    assign skid_we   = r_skid_we & w_skid_vld;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench for pipe_skid_stage. Directed scenarios are
//            followed by randomized traffic, all compared each cycle against a
//            queue-based reference model. It follows PIPE_SKID_STALL_CNT_EN
//            when that macro is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int DATA_W = 64;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_we;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .skid_rd   (skid_rd),
        .skid_we   (skid_we),
        .stall_cnt (stall_cnt)
    );

    // Reference model: a FIFO of up to two entries. It also tracks the last
    // entry shown in each slot, because payload fields hold when invalid.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              we;
    } ent_t;

    ent_t q[$];
    ent_t m_main;
    ent_t m_skid;
    int   m_cnt;
    bit   last_infire;
    int   n_cmp;
    int   n_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_main = '0;
        m_skid = '0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs();
        int exp_cnt;
`ifdef PIPE_SKID_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("out_data",  out_data,       m_main.data);
        check("out_rd",    64'(out_rd),    64'(m_main.rd));
        check("out_we",    64'(out_we),    64'((q.size() > 0) && m_main.we));
        check("skid_rd",   64'(skid_rd),   64'(m_skid.rd));
        check("skid_we",   64'(skid_we),   64'((q.size() == 2) && m_skid.we));
        check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    endtask

    // Advance one clock using the inputs currently driven, then check at the
    // following falling edge.
    task automatic step();
        bit   infire;
        bit   ofire;
        ent_t e;
        @(posedge clk);
        infire = in_valid && (q.size() < 2);
        ofire  = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (infire) begin
                e.data = in_data;
                e.rd   = in_rd;
                e.we   = in_we;
                q.push_back(e);
            end
        end
        if (q.size() > 0)  m_main = q[0];
        if (q.size() == 2) m_skid = q[1];
        last_infire = infire;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd, input logic we);
        in_valid = 1'b1;
        in_data  = d;
        in_rd    = rd;
        in_we    = we;
    endtask

    // Random stimulus. An offer that was not accepted is held stable.
    task automatic drive_rand(input int flush_pct);
        if (!(in_valid && !last_infire)) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = {$urandom(), $urandom()};
            in_rd    = RD_W'($urandom);
            in_we    = 1'($urandom);
        end
        out_ready = ($urandom % 3) != 0;
        flush     = $urandom_range(0, 99) < flush_pct;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        last_infire = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        last_infire = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_rd = '0;
        in_we = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // Streaming at full rate: one cycle latency, no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(64'h11 + 64'(i), RD_W'(i + 1), 1'b1);
            step();
            check("t1_in_ready", 64'(in_ready), 64'd1);
            check("t1_data", out_data, 64'h11 + 64'(i));
        end
        in_valid = 1'b0;
        step();

        // Backpressure: 0x21 in main, 0x22 in skid, 0x23 held off.
        out_ready = 1'b0;
        offer(64'h21, 5'd1, 1'b0); step();
        offer(64'h22, 5'd2, 1'b1); step();
        offer(64'h23, 5'd3, 1'b1); step();
        check("t2_full_ready", 64'(in_ready), 64'd0);
        check("t2_head", out_data, 64'h21);
        check("t2_skid_rd", 64'(skid_rd), 64'd2);
        out_ready = 1'b1;
        step(); check("t2_drain0", out_data, 64'h22);
        step(); check("t2_drain1", out_data, 64'h23);
        in_valid = 1'b0;
        step();

        // Flush while FULL, with a simultaneous offer that must be discarded.
        out_ready = 1'b0;
        offer(64'h31, 5'd3, 1'b1); step();
        offer(64'h32, 5'd7, 1'b1); step();
        check("t3_skid_we", 64'(skid_we), 64'd1);
        flush = 1'b1;
        offer(64'h55, 5'd12, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t3_out_valid", 64'(out_valid), 64'd0);
        check("t3_out_we", 64'(out_we), 64'd0);
        check("t3_skid_we0", 64'(skid_we), 64'd0);
        check("t3_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_no55", 64'(out_data == 64'h55), 64'd0);
        end
        check("t3_rd_held", 64'(out_rd), 64'd3);

        // A write entry followed by a flush: rd may hold but we must drop.
        out_ready = 1'b0;
        offer(64'h41, 5'd9, 1'b1); step();
        in_valid = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0;
        check("t4_rd", 64'(out_rd), 64'd9);
        check("t4_we", 64'(out_we), 64'd0);

        // Long stall on a FULL buffer drives the counter into saturation.
        offer(64'h61, 5'd4, 1'b1); step();
        offer(64'h62, 5'd5, 1'b0); step();
        in_valid = 1'b0;
        repeat (20) step();
`ifdef PIPE_SKID_STALL_CNT_EN
        check("t5_sat", 64'(stall_cnt), 64'(CNT_MAX));
`else
        check("t5_off", 64'(stall_cnt), 64'd0);
`endif

        // Asynchronous reset in the middle of the low clock phase while FULL.
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
        check("t6_skid_we", 64'(skid_we), 64'd0);
        check("t6_out_data", out_data, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        last_infire = 1'b0;
        check_outputs();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            drive_rand(4);
            step();
        end
        flush = 1'b0;

        // Second reset followed by more traffic without flushes.
        in_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            drive_rand(0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
